// File: rtl/regfile_wb_arbiter.sv
// Register file writeback arbiter.
// Two writeback sources (ALU result path and memory/load path) each feed a
// one-entry holding buffer through a valid/ready handshake. A round-robin
// arbiter drains the buffers onto a registered register file write port.
// Writes to register 0 use up their grant slot but never raise RegWrite.
module regfile_wb_arbiter #(
   parameter int CNT_W     = 16,
   parameter bit MEM_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_valid,
   output logic             alu_ready,
   input  logic [4:0]       alu_reg,
   input  logic [31:0]      alu_data,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic [4:0]       mem_reg,
   input  logic [31:0]      mem_data,
   output logic             RegWrite,
   output logic [4:0]       Write_reg,
   output logic [31:0]      Data,
   output logic [CNT_W-1:0] conflict_cnt
);

   logic        full_alu;
   logic        full_mem;
   logic [4:0]  reg_alu;
   logic [4:0]  reg_mem;
   logic [31:0] data_alu;
   logic [31:0] data_mem;
   logic        ptr_mem;

   logic        both_full;
   logic        grant_alu;
   logic        grant_mem;
   logic        grant_any;
   logic [4:0]  grant_reg;
   logic [31:0] grant_data;
   logic        xfer_alu;
   logic        xfer_mem;

   // Grant depends only on registered full flags and the pointer, so ready never sees valid
   always_comb begin
      both_full  = full_alu & full_mem;
      grant_alu  = full_alu & (~full_mem | ~ptr_mem);
      grant_mem  = full_mem & (~full_alu | ptr_mem);
      grant_any  = grant_alu | grant_mem;
      grant_reg  = grant_mem ? reg_mem  : reg_alu;
      grant_data = grant_mem ? data_mem : data_alu;
   end

   // A buffer draining this cycle can take a new entry at the same edge
   assign alu_ready = ~full_alu | grant_alu;
   assign mem_ready = ~full_mem | grant_mem;
   assign xfer_alu  = alu_valid & alu_ready;
   assign xfer_mem  = mem_valid & mem_ready;

   // Holding buffers: load on handshake, empty when granted with nothing arriving
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full_alu <= 1'b0;
         full_mem <= 1'b0;
         reg_alu  <= '0;
         reg_mem  <= '0;
         data_alu <= '0;
         data_mem <= '0;
      end else begin
         if (xfer_alu) begin
            full_alu <= 1'b1;
            reg_alu  <= alu_reg;
            data_alu <= alu_data;
         end else if (grant_alu) begin
            full_alu <= 1'b0;
         end
         if (xfer_mem) begin
            full_mem <= 1'b1;
            reg_mem  <= mem_reg;
            data_mem <= mem_data;
         end else if (grant_mem) begin
            full_mem <= 1'b0;
         end
      end
   end

   // Registered write port; address and data hold when nothing is granted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         RegWrite  <= 1'b0;
         Write_reg <= '0;
         Data      <= '0;
      end else begin
         RegWrite <= grant_any & (grant_reg != 5'd0);
         if (grant_any) begin
            Write_reg <= grant_reg;
            Data      <= grant_data;
         end
      end
   end

   // Pointer alternates only on conflicts; the saturating counter tallies them
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_mem      <= MEM_FIRST;
         conflict_cnt <= '0;
      end else if (both_full) begin
         ptr_mem <= ~ptr_mem;
         if (conflict_cnt != {CNT_W{1'b1}}) begin
            conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter.
// Drives directed scenarios and a randomized phase, checking every cycle
// against a queue-based model of the two buffers and the round-robin rule.
module tb_regfile_wb_arbiter;

   localparam int CNT_W     = 4;
   localparam bit MEM_FIRST = 1'b1;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             alu_valid;
   logic             alu_ready;
   logic [4:0]       alu_reg;
   logic [31:0]      alu_data;
   logic             mem_valid;
   logic             mem_ready;
   logic [4:0]       mem_reg;
   logic [31:0]      mem_data;
   logic             RegWrite;
   logic [4:0]       Write_reg;
   logic [31:0]      Data;
   logic [CNT_W-1:0] conflict_cnt;

   regfile_wb_arbiter #(
      .CNT_W     (CNT_W),
      .MEM_FIRST (MEM_FIRST)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_reg      (alu_reg),
      .alu_data     (alu_data),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_reg      (mem_reg),
      .mem_data     (mem_data),
      .RegWrite     (RegWrite),
      .Write_reg    (Write_reg),
      .Data         (Data),
      .conflict_cnt (conflict_cnt)
   );

   // Free-running clock
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
   } wr_t;

   typedef struct packed {
      logic             we;
      logic [4:0]       r;
      logic [31:0]      d;
      logic [CNT_W-1:0] cnt;
   } obs_t;

   wr_t  alu_src[$];
   wr_t  mem_src[$];
   bit   alu_on;
   bit   mem_on;
   bit   rand_valid;

   wr_t  alu_m[$];
   wr_t  mem_m[$];
   bit   ptr_m;
   bit   exp_we;
   logic [4:0]  exp_reg;
   logic [31:0] exp_data;
   int   exp_cnt;
   bit   model_valid = 1'b0;

   logic [31:0] model_rf[32];
   logic [31:0] dut_rf[32];
   obs_t log_q[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // 0: nothing pending, 1: ALU wins, 2: memory wins
   function automatic int pickSource();
      if (alu_m.size() > 0 && mem_m.size() > 0) return ptr_m ? 2 : 1;
      if (alu_m.size() > 0) return 1;
      if (mem_m.size() > 0) return 2;
      return 0;
   endfunction

   task automatic checkOutput();
      obs_t o;
      if (!model_valid) return;
      check("RegWrite", RegWrite, exp_we);
      check("Write_reg", Write_reg, exp_reg);
      check("Data", Data, exp_data);
      check("conflict_cnt", conflict_cnt, exp_cnt);
      o.we  = RegWrite;
      o.r   = Write_reg;
      o.d   = Data;
      o.cnt = conflict_cnt;
      log_q.push_back(o);
      if (RegWrite === 1'b1) dut_rf[Write_reg] = Data;
   endtask

   task automatic applyStimulus(input bit rn);
      int  g;
      bit  ra;
      bit  rm;
      bit  both;
      wr_t w;
      if (!alu_on && alu_src.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) alu_on = 1'b1;
      if (!mem_on && mem_src.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) mem_on = 1'b1;
      rst_n     = rn;
      alu_valid = alu_on;
      alu_reg   = alu_on ? alu_src[0].r : 5'($urandom);
      alu_data  = alu_on ? alu_src[0].d : $urandom;
      mem_valid = mem_on;
      mem_reg   = mem_on ? mem_src[0].r : 5'($urandom);
      mem_data  = mem_on ? mem_src[0].d : $urandom;

      g  = pickSource();
      ra = (alu_m.size() == 0) || (g == 1);
      rm = (mem_m.size() == 0) || (g == 2);
      if (model_valid) begin
         check("alu_ready", alu_ready, ra);
         check("mem_ready", mem_ready, rm);
      end

      if (!rn) begin
         alu_m.delete();
         mem_m.delete();
         ptr_m       = MEM_FIRST;
         exp_we      = 1'b0;
         exp_reg     = '0;
         exp_data    = '0;
         exp_cnt     = 0;
         model_valid = 1'b1;
      end else begin
         both = (alu_m.size() > 0) && (mem_m.size() > 0);
         w    = '0;
         if (g == 1) w = alu_m.pop_front();
         else if (g == 2) w = mem_m.pop_front();
         if (g != 0) begin
            exp_we   = (w.r != 5'd0);
            exp_reg  = w.r;
            exp_data = w.d;
            if (w.r != 5'd0) model_rf[w.r] = w.d;
         end else begin
            exp_we = 1'b0;
         end
         if (both) begin
            ptr_m = !ptr_m;
            if (exp_cnt < CNT_MAX) exp_cnt++;
         end
         if (alu_on && ra) begin
            alu_m.push_back(alu_src.pop_front());
            alu_on = 1'b0;
         end
         if (mem_on && rm) begin
            mem_m.push_back(mem_src.pop_front());
            mem_on = 1'b0;
         end
      end

      @(negedge clk);
      checkOutput();
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b1);
   endtask

   task automatic resetDut();
      alu_src.delete();
      mem_src.delete();
      alu_on = 1'b0;
      mem_on = 1'b0;
      applyStimulus(1'b0);
      log_q.delete();
   endtask

   task automatic checkLog(input string name, input int idx, input bit we, input logic [4:0] r, input logic [31:0] d);
      check({name, "_we"},   log_q[idx].we, we);
      check({name, "_reg"},  log_q[idx].r, r);
      check({name, "_data"}, log_q[idx].d, d);
   endtask

   // Directed scenarios, randomized traffic, then register file comparison
   initial begin
      rst_n = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
      alu_reg = '0; alu_data = '0; mem_reg = '0; mem_data = '0;
      alu_on = 1'b0; mem_on = 1'b0; rand_valid = 1'b0;
      for (int i = 0; i < 32; i++) begin
         model_rf[i] = '0;
         dut_rf[i]   = '0;
      end
      @(negedge clk);

      alu_src.push_back('{r: 5'd1, d: 32'h1});
      mem_src.push_back('{r: 5'd2, d: 32'h2});
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      check("rst_RegWrite", RegWrite, 0);
      check("rst_Write_reg", Write_reg, 0);
      check("rst_Data", Data, 0);
      check("rst_cnt", conflict_cnt, 0);
      check("rst_alu_ready", alu_ready, 1);
      check("rst_mem_ready", mem_ready, 1);
      log_q.delete();
      idle(4);
      check("rst_first_no_pulse", log_q[0].we, 0);

      resetDut();
      for (int i = 0; i < 4; i++) alu_src.push_back('{r: 5'd8, d: 32'h11 * (i + 1)});
      idle(6);
      check("alu_idle_first", log_q[0].we, 0);
      checkLog("alu_w0", 1, 1'b1, 5'd8, 32'h11);
      checkLog("alu_w1", 2, 1'b1, 5'd8, 32'h22);
      checkLog("alu_w3", 4, 1'b1, 5'd8, 32'h44);

      resetDut();
      for (int i = 0; i < 12; i++) begin
         alu_src.push_back('{r: 5'd9,  d: 32'hA0 + i});
         mem_src.push_back('{r: 5'd10, d: 32'hB0 + i});
      end
      idle(30);
      checkLog("cf_mem0", 1, 1'b1, 5'd10, 32'hB0);
      check("cf_cnt1", log_q[1].cnt, 1);
      checkLog("cf_alu0", 2, 1'b1, 5'd9, 32'hA0);
      check("cf_cnt2", log_q[2].cnt, 2);
      checkLog("cf_mem1", 3, 1'b1, 5'd10, 32'hB1);
      check("cf_cnt_sat", conflict_cnt, CNT_MAX);

      resetDut();
      mem_src.push_back('{r: 5'd0, d: 32'hDEAD});
      mem_src.push_back('{r: 5'd2, d: 32'h5});
      idle(5);
      checkLog("r0_drop", 1, 1'b0, 5'd0, 32'hDEAD);
      checkLog("r0_next", 2, 1'b1, 5'd2, 32'h5);

      resetDut();
      alu_src.push_back('{r: 5'd5, d: 32'h55});
      mem_src.push_back('{r: 5'd6, d: 32'h66});
      idle(4);
      alu_src.push_back('{r: 5'd4, d: 32'h1});
      mem_src.push_back('{r: 5'd4, d: 32'h2});
      log_q.delete();
      idle(5);
      checkLog("same_alu", 1, 1'b1, 5'd4, 32'h1);
      checkLog("same_mem", 2, 1'b1, 5'd4, 32'h2);
      check("same_rf4", dut_rf[4], 32'h2);
      check("same_model_rf4", model_rf[4], 32'h2);

      resetDut();
      alu_src.push_back('{r: 5'd7, d: 32'h70});
      alu_src.push_back('{r: 5'd7, d: 32'h71});
      mem_src.push_back('{r: 5'd11, d: 32'hC0});
      mem_src.push_back('{r: 5'd11, d: 32'hC1});
      idle(2);
      alu_src.delete(); mem_src.delete(); alu_on = 1'b0; mem_on = 1'b0;
      log_q.delete();
      applyStimulus(1'b0);
      idle(4);
      check("mid_rst_we", log_q[0].we, 0);
      check("mid_rst_cnt", log_q[0].cnt, 0);
      for (int i = 1; i < 5; i++) check("mid_rst_no_write", log_q[i].we, 0);
      log_q.delete();
      alu_src.push_back('{r: 5'd12, d: 32'hE1});
      mem_src.push_back('{r: 5'd13, d: 32'hE2});
      idle(4);
      checkLog("mid_rst_ptr", 1, 1'b1, 5'd13, 32'hE2);

      rand_valid = 1'b1;
      for (int c = 0; c < 600; c++) begin
         if (alu_src.size() < 3 && $urandom_range(0, 1) == 1)
            alu_src.push_back('{r: ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), d: $urandom});
         if (mem_src.size() < 3 && $urandom_range(0, 1) == 1)
            mem_src.push_back('{r: ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), d: $urandom});
         applyStimulus(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0);
      end
      rand_valid = 1'b0;
      idle(20);
      for (int i = 0; i < 32; i++) check("rf_final", dut_rf[i], model_rf[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
